spi_slave_burst_controller: RTL and testbench

- Next-generation SPI slave protocol controller; sits between the SPI shift registers (rx/tx) and the system-side bus adapter.
- Generalises the single-lane controller:
  - parametrised command, address and data widths;
  - dual/quad lane data phases;
  - auto-incrementing burst addressing with optional wrap window;
  - TX underrun detection;
  - illegal-command handling.
- Internal config registers: dummy cycles and wrap length.

---
 rtl/spi_slave_burst_controller.sv | 246 ++++++++++++++++++++++++
 tb/tb_spi_slave_burst_controller.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_burst_controller.sv
// SPI slave burst controller: sequences command, address, dummy and data
// phases between the SPI rx/tx shifters and the system bus adapter.
// Handshake rule: every *_valid / *_ready / *_upd output is a registered
// one-sclk pulse raised on the edge after its triggering rx_data_valid,
// tx_done or ready event; inputs are sampled only on sclk rising edges.
// Config registers (dummy cycles, wrap length) are never cleared by cs.
module spi_slave_burst_controller #(
    parameter int CMD_WIDTH  = 8,
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_LANES  = 4,
    parameter int DUMMY_RST  = 8,
    parameter int CNT_W      = 8,
    localparam int RX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH
) (
    input  logic                  sclk,
    input  logic                  cs,
    input  logic [RX_W-1:0]       rx_data,
    input  logic                  rx_data_valid,
    output logic [CNT_W-1:0]      rx_counter,
    output logic                  rx_counter_upd,
    output logic [CNT_W-1:0]      tx_counter,
    output logic                  tx_counter_upd,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_data_valid,
    input  logic                  tx_done,
    output logic [1:0]            lanes,
    output logic                  ctrl_rd_wr,
    output logic [ADDR_WIDTH-1:0] ctrl_addr,
    output logic                  ctrl_addr_valid,
    output logic [DATA_WIDTH-1:0] ctrl_data_rx,
    output logic                  ctrl_data_rx_valid,
    input  logic [DATA_WIDTH-1:0] ctrl_data_tx,
    input  logic                  ctrl_data_tx_valid,
    output logic                  ctrl_data_tx_ready,
    output logic                  underrun,
    output logic                  illegal_cmd,
    output logic [15:0]           wrap_length,
    output logic [2:0]            state_dbg
);

    localparam logic [2:0] S_CMD     = 3'd0;
    localparam logic [2:0] S_ADDR    = 3'd1;
    localparam logic [2:0] S_DUMMY   = 3'd2;
    localparam logic [2:0] S_DATA_RX = 3'd3;
    localparam logic [2:0] S_DATA_TX = 3'd4;
    localparam logic [2:0] S_REG_RX  = 3'd5;
    localparam logic [2:0] S_REG_TX  = 3'd6;
    localparam logic [2:0] S_IGNORE  = 3'd7;

    localparam int STEP = DATA_WIDTH / 8;
    // Register select lives above the 8-bit opcode; empty when CMD_WIDTH = 8.
    localparam logic [RX_W-1:0] SEL_MASK = RX_W'((64'd1 << (CMD_WIDTH - 8)) - 64'd1);

    // Beats minus one for a field of 'bits' shifted on 2**code lanes.
    function automatic logic [CNT_W-1:0] beats(input int bits, input logic [1:0] code);
        return CNT_W'((bits >> code) - 1);
    endfunction

    function automatic int lane_cnt(input logic [1:0] code);
        return 1 << code;
    endfunction

    logic [2:0]            state;
    logic                  has_dummy;
    logic                  sel0, sel1;
    logic [CNT_W-1:0]      dummy_cycles = CNT_W'(DUMMY_RST);
    logic [15:0]           wrap_q       = 16'd0;

    logic                  dec_ok, dec_mem, dec_rd, dec_dummy, dec_reg_wr;
    logic [1:0]            dec_lanes;
    logic [RX_W-1:0]       sel_val;
    logic                  sel_is0, sel_is1;
    logic [DATA_WIDTH-1:0] reg_rd_val;
    logic [ADDR_WIDTH-1:0] win_mask, addr_inc, addr_next;
    logic                  wrap_on;

    assign state_dbg   = state;
    assign wrap_length = wrap_q;

    // Opcode decode and register select of the word currently on rx_data.
    always_comb begin
        dec_ok     = 1'b1;
        dec_mem    = 1'b1;
        dec_rd     = 1'b0;
        dec_dummy  = 1'b0;
        dec_reg_wr = 1'b0;
        dec_lanes  = 2'd0;
        case (rx_data[7:0])
            8'h03: dec_rd = 1'b1;
            8'h0B: begin dec_rd = 1'b1; dec_dummy = 1'b1; end
            8'h6B: begin dec_rd = 1'b1; dec_dummy = 1'b1; dec_lanes = 2'd1; end
            8'hEB: begin dec_rd = 1'b1; dec_dummy = 1'b1; dec_lanes = 2'd2; end
            8'h02: dec_rd = 1'b0;
            8'h32: dec_lanes = 2'd2;
            8'h11: begin dec_mem = 1'b0; dec_reg_wr = 1'b1; end
            8'h21: dec_mem = 1'b0;
            default: dec_ok = 1'b0;
        endcase
        if (lane_cnt(dec_lanes) > MAX_LANES) dec_ok = 1'b0;
        sel_val    = (rx_data >> 8) & SEL_MASK;
        sel_is0    = (sel_val == '0);
        sel_is1    = (sel_val == RX_W'(1));
        reg_rd_val = '0;
        if (sel_is0) reg_rd_val = DATA_WIDTH'(dummy_cycles);
        if (sel_is1) reg_rd_val = DATA_WIDTH'(wrap_q);
    end

    // Next burst address: linear, or wrapped inside an aligned power-of-two window.
    always_comb begin
        wrap_on   = (wrap_q != 16'd0) && ((wrap_q & (wrap_q - 16'd1)) == 16'd0);
        win_mask  = ADDR_WIDTH'(wrap_q) * ADDR_WIDTH'(STEP) - ADDR_WIDTH'(1);
        addr_inc  = ctrl_addr + ADDR_WIDTH'(STEP);
        addr_next = wrap_on ? ((ctrl_addr & ~win_mask) | (addr_inc & win_mask)) : addr_inc;
    end

    // Config registers: written from REG_RX, deliberately untouched by cs.
    always_ff @(posedge sclk) begin
        if (state == S_REG_RX && rx_data_valid) begin
            if (sel0) dummy_cycles <= rx_data[CNT_W-1:0];
            if (sel1) wrap_q       <= rx_data[15:0];
        end
    end

    // Protocol FSM and registered outputs; cs high holds everything in reset.
    always_ff @(posedge sclk or posedge cs) begin
        if (cs) begin
            state              <= S_CMD;
            rx_counter         <= CNT_W'(CMD_WIDTH - 1);
            rx_counter_upd     <= 1'b0;
            tx_counter         <= '0;
            tx_counter_upd     <= 1'b0;
            tx_data            <= '0;
            tx_data_valid      <= 1'b0;
            lanes              <= 2'd0;
            ctrl_rd_wr         <= 1'b0;
            ctrl_addr          <= '0;
            ctrl_addr_valid    <= 1'b0;
            ctrl_data_rx       <= '0;
            ctrl_data_rx_valid <= 1'b0;
            ctrl_data_tx_ready <= 1'b0;
            underrun           <= 1'b0;
            illegal_cmd        <= 1'b0;
            has_dummy          <= 1'b0;
            sel0               <= 1'b0;
            sel1               <= 1'b0;
        end else begin
            rx_counter_upd     <= 1'b0;
            tx_counter_upd     <= 1'b0;
            tx_data_valid      <= 1'b0;
            ctrl_addr_valid    <= 1'b0;
            ctrl_data_rx_valid <= 1'b0;
            ctrl_data_tx_ready <= 1'b0;
            case (state)
                S_CMD: if (rx_data_valid) begin
                    if (!dec_ok) begin
                        state       <= S_IGNORE;
                        illegal_cmd <= 1'b1;
                    end else if (dec_mem) begin
                        state          <= S_ADDR;
                        lanes          <= dec_lanes;
                        ctrl_rd_wr     <= dec_rd;
                        has_dummy      <= dec_dummy;
                        rx_counter     <= beats(ADDR_WIDTH, dec_lanes);
                        rx_counter_upd <= 1'b1;
                    end else begin
                        sel0 <= sel_is0;
                        sel1 <= sel_is1;
                        if (dec_reg_wr) begin
                            state          <= S_REG_RX;
                            rx_counter     <= beats(DATA_WIDTH, 2'd0);
                            rx_counter_upd <= 1'b1;
                        end else begin
                            state          <= S_REG_TX;
                            tx_data        <= reg_rd_val;
                            tx_data_valid  <= 1'b1;
                            tx_counter     <= beats(DATA_WIDTH, 2'd0);
                            tx_counter_upd <= 1'b1;
                        end
                    end
                end
                S_ADDR: if (rx_data_valid) begin
                    ctrl_addr       <= rx_data[ADDR_WIDTH-1:0];
                    ctrl_addr_valid <= 1'b1;
                    if (!ctrl_rd_wr) begin
                        state          <= S_DATA_RX;
                        rx_counter     <= beats(DATA_WIDTH, lanes);
                        rx_counter_upd <= 1'b1;
                    end else if (has_dummy && dummy_cycles != '0) begin
                        state          <= S_DUMMY;
                        rx_counter     <= dummy_cycles - CNT_W'(1);
                        rx_counter_upd <= 1'b1;
                    end else begin
                        state              <= S_DATA_TX;
                        ctrl_data_tx_ready <= 1'b1;
                    end
                end
                S_DUMMY: if (rx_data_valid) begin
                    state              <= S_DATA_TX;
                    ctrl_data_tx_ready <= 1'b1;
                end
                S_DATA_RX: begin
                    if (rx_data_valid) begin
                        ctrl_data_rx       <= rx_data[DATA_WIDTH-1:0];
                        ctrl_data_rx_valid <= 1'b1;
                        rx_counter         <= beats(DATA_WIDTH, lanes);
                        rx_counter_upd     <= 1'b1;
                    end
                    // The write strobe of the previous cycle moves the burst on.
                    if (ctrl_data_rx_valid) begin
                        ctrl_addr       <= addr_next;
                        ctrl_addr_valid <= 1'b1;
                    end
                end
                S_DATA_TX: begin
                    // The cycle after a pop request the bus data is either there or not.
                    if (ctrl_data_tx_ready) begin
                        tx_data        <= ctrl_data_tx_valid ? ctrl_data_tx : '0;
                        if (!ctrl_data_tx_valid) underrun <= 1'b1;
                        tx_data_valid  <= 1'b1;
                        tx_counter     <= beats(DATA_WIDTH, lanes);
                        tx_counter_upd <= 1'b1;
                    end
                    if (tx_done) begin
                        ctrl_addr          <= addr_next;
                        ctrl_addr_valid    <= 1'b1;
                        ctrl_data_tx_ready <= 1'b1;
                    end
                end
                S_REG_RX: if (rx_data_valid) begin
                    state          <= S_CMD;
                    rx_counter     <= CNT_W'(CMD_WIDTH - 1);
                    rx_counter_upd <= 1'b1;
                end
                S_REG_TX: if (tx_done) begin
                    state          <= S_CMD;
                    rx_counter     <= CNT_W'(CMD_WIDTH - 1);
                    rx_counter_upd <= 1'b1;
                end
                S_IGNORE: state <= S_IGNORE;
                default:  state <= S_CMD;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_burst_controller.sv
// Self-checking bench for spi_slave_burst_controller (CMD_WIDTH = 16 so that
// register select bits exist). Inputs change on falling sclk, outputs are
// observed on falling sclk.
module tb_spi_slave_burst_controller;

    localparam int CMD_W = 16;

    localparam logic [2:0] S_CMD     = 3'd0;
    localparam logic [2:0] S_ADDR    = 3'd1;
    localparam logic [2:0] S_DUMMY   = 3'd2;
    localparam logic [2:0] S_DATA_RX = 3'd3;
    localparam logic [2:0] S_DATA_TX = 3'd4;
    localparam logic [2:0] S_REG_RX  = 3'd5;
    localparam logic [2:0] S_IGNORE  = 3'd7;

    logic        sclk = 1'b0;
    logic        cs = 1'b1;
    logic [31:0] rx_data = '0;
    logic        rx_data_valid = 1'b0;
    logic [7:0]  rx_counter, tx_counter;
    logic        rx_counter_upd, tx_counter_upd;
    logic [31:0] tx_data;
    logic        tx_data_valid;
    logic        tx_done = 1'b0;
    logic [1:0]  lanes;
    logic        ctrl_rd_wr;
    logic [23:0] ctrl_addr;
    logic        ctrl_addr_valid;
    logic [31:0] ctrl_data_rx;
    logic        ctrl_data_rx_valid;
    logic [31:0] ctrl_data_tx = '0;
    logic        ctrl_data_tx_valid = 1'b0;
    logic        ctrl_data_tx_ready;
    logic        underrun, illegal_cmd;
    logic [15:0] wrap_length;
    logic [2:0]  state_dbg;

    int checks = 0;
    int failures = 0;

    logic [23:0] exp_addr_q[$];
    logic [31:0] exp_wr_q[$];
    logic [31:0] exp_tx_q[$];
    logic [23:0] ea;
    logic [31:0] ed;

    spi_slave_burst_controller #(.CMD_WIDTH(CMD_W)) dut (
        .sclk(sclk), .cs(cs), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
        .rx_counter(rx_counter), .rx_counter_upd(rx_counter_upd),
        .tx_counter(tx_counter), .tx_counter_upd(tx_counter_upd),
        .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_done(tx_done),
        .lanes(lanes), .ctrl_rd_wr(ctrl_rd_wr), .ctrl_addr(ctrl_addr),
        .ctrl_addr_valid(ctrl_addr_valid), .ctrl_data_rx(ctrl_data_rx),
        .ctrl_data_rx_valid(ctrl_data_rx_valid), .ctrl_data_tx(ctrl_data_tx),
        .ctrl_data_tx_valid(ctrl_data_tx_valid), .ctrl_data_tx_ready(ctrl_data_tx_ready),
        .underrun(underrun), .illegal_cmd(illegal_cmd), .wrap_length(wrap_length),
        .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 sclk = ~sclk;

    // ---------------- scoreboard monitor ----------------
    always @(negedge sclk) begin
        if (ctrl_addr_valid) begin
            checks++;
            if (exp_addr_q.size() == 0) begin
                failures++;
                $display("FAIL addr_unexpected got=%h", ctrl_addr);
            end else begin
                ea = exp_addr_q.pop_front();
                if (ctrl_addr !== ea) begin
                    failures++;
                    $display("FAIL ctrl_addr got=%h exp=%h", ctrl_addr, ea);
                end
            end
        end
        if (ctrl_data_rx_valid) begin
            checks++;
            if (exp_wr_q.size() == 0) begin
                failures++;
                $display("FAIL wdata_unexpected got=%h", ctrl_data_rx);
            end else begin
                ed = exp_wr_q.pop_front();
                if (ctrl_data_rx !== ed) begin
                    failures++;
                    $display("FAIL ctrl_data_rx got=%h exp=%h", ctrl_data_rx, ed);
                end
            end
        end
        if (tx_data_valid) begin
            checks++;
            if (exp_tx_q.size() == 0) begin
                failures++;
                $display("FAIL tx_unexpected got=%h", tx_data);
            end else begin
                ed = exp_tx_q.pop_front();
                if (tx_data !== ed) begin
                    failures++;
                    $display("FAIL tx_data got=%h exp=%h", tx_data, ed);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge sclk);
    endtask

    // Shifter completes a field: one-cycle rx_data_valid after 'gap' idle cycles.
    task automatic rx_word(input logic [31:0] v, input int gap);
        tick(gap);
        rx_data = v;
        rx_data_valid = 1'b1;
        tick(1);
        rx_data_valid = 1'b0;
    endtask

    task automatic tx_done_pulse(input int gap);
        tick(gap);
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
    endtask

    task automatic deselect();
        cs = 1'b1;
        tick(2);
        cs = 1'b0;
        tick(1);
    endtask

    task automatic reg_write(input logic [7:0] sel, input logic [31:0] v);
        rx_word({16'h0, sel, 8'h11}, 2);
        rx_word(v, 3);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        tick(3);
        checks++;
        if (state_dbg !== S_CMD || rx_counter !== 8'(CMD_W - 1) || lanes !== 2'd0) begin
            failures++;
            $display("FAIL reset_state st=%0d rxc=%0d lanes=%0d exp st=0 rxc=%0d lanes=0",
                     state_dbg, rx_counter, lanes, CMD_W - 1);
        end
        checks++;
        if ({ctrl_addr_valid, ctrl_data_rx_valid, ctrl_data_tx_ready, tx_data_valid,
             rx_counter_upd, tx_counter_upd, underrun, illegal_cmd} !== 8'h0 ||
            tx_data !== 32'h0 || ctrl_addr !== 24'h0 || wrap_length !== 16'h0) begin
            failures++;
            $display("FAIL reset_outputs nonzero output found, exp all 0");
        end
        cs = 1'b0;
        tick(1);
    endtask

    task automatic test_write_burst();
        logic [31:0] words[3];
        words[0] = 32'hA5A5A5A5; words[1] = 32'h1; words[2] = 32'h2;
        exp_addr_q.push_back(24'h100); exp_addr_q.push_back(24'h104);
        exp_addr_q.push_back(24'h108); exp_addr_q.push_back(24'h10C);
        for (int i = 0; i < 3; i++) exp_wr_q.push_back(words[i]);
        rx_word(32'h0002, 3);
        checks++;
        if (rx_counter !== 8'd23 || rx_counter_upd !== 1'b1 || state_dbg !== S_ADDR) begin
            failures++;
            $display("FAIL wr_addr_counter rxc=%0d upd=%b st=%0d exp 23 1 %0d", rx_counter, rx_counter_upd, state_dbg, S_ADDR);
        end
        rx_word(32'h000100, 2);
        checks++;
        if (rx_counter !== 8'd31 || state_dbg !== S_DATA_RX || ctrl_rd_wr !== 1'b0) begin
            failures++;
            $display("FAIL wr_data_counter rxc=%0d st=%0d rdwr=%b exp 31 %0d 0", rx_counter, state_dbg, ctrl_rd_wr, S_DATA_RX);
        end
        for (int i = 0; i < 3; i++) rx_word(words[i], $urandom_range(2, 5));
        tick(3);
        checks++;
        if (exp_addr_q.size() != 0 || exp_wr_q.size() != 0) begin
            failures++;
            $display("FAIL wr_queues addr_left=%0d wr_left=%0d exp 0 0", exp_addr_q.size(), exp_wr_q.size());
        end
        deselect();
    endtask

    task automatic test_quad_read();
        rx_word(32'h00EB, 2);
        checks++;
        if (lanes !== 2'd2 || rx_counter !== 8'd5) begin
            failures++;
            $display("FAIL quad_cmd lanes=%0d rxc=%0d exp 2 5", lanes, rx_counter);
        end
        exp_addr_q.push_back(24'h10);
        rx_word(32'h10, 2);
        checks++;
        if (rx_counter !== 8'd7 || state_dbg !== S_DUMMY) begin
            failures++;
            $display("FAIL quad_dummy rxc=%0d st=%0d exp 7 %0d", rx_counter, state_dbg, S_DUMMY);
        end
        ctrl_data_tx = 32'hDEADBEEF; ctrl_data_tx_valid = 1'b1;
        exp_tx_q.push_back(32'hDEADBEEF);
        rx_word(32'h0, 4);
        checks++;
        if (ctrl_data_tx_ready !== 1'b1 || state_dbg !== S_DATA_TX) begin
            failures++;
            $display("FAIL quad_ready rdy=%b st=%0d exp 1 %0d", ctrl_data_tx_ready, state_dbg, S_DATA_TX);
        end
        tick(1);
        checks++;
        if (tx_data_valid !== 1'b1 || tx_counter !== 8'd7 || tx_counter_upd !== 1'b1 || ctrl_data_tx_ready !== 1'b0) begin
            failures++;
            $display("FAIL quad_tx_load txv=%b txc=%0d upd=%b rdy=%b exp 1 7 1 0", tx_data_valid, tx_counter, tx_counter_upd, ctrl_data_tx_ready);
        end
        ctrl_data_tx = 32'hCAFEF00D;
        exp_addr_q.push_back(24'h14);
        exp_tx_q.push_back(32'hCAFEF00D);
        tx_done_pulse(5);
        checks++;
        if (ctrl_data_tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL quad_ready_on_done rdy=%b exp 1", ctrl_data_tx_ready);
        end
        tick(1);
        checks++;
        if (ctrl_data_tx_ready !== 1'b0 || underrun !== 1'b0) begin
            failures++;
            $display("FAIL quad_single_ready rdy=%b underrun=%b exp 0 0", ctrl_data_tx_ready, underrun);
        end
        deselect();
    endtask

    task automatic test_wrap();
        rx_word(32'h0111, 2);
        checks++;
        if (state_dbg !== S_REG_RX || rx_counter !== 8'd31) begin
            failures++;
            $display("FAIL regwr_phase st=%0d rxc=%0d exp %0d 31", state_dbg, rx_counter, S_REG_RX);
        end
        rx_word(32'd4, 3);
        checks++;
        if (wrap_length !== 16'd4 || state_dbg !== S_CMD || rx_counter !== 8'(CMD_W - 1)) begin
            failures++;
            $display("FAIL regwr_done wrap=%0d st=%0d rxc=%0d exp 4 0 %0d", wrap_length, state_dbg, rx_counter, CMD_W - 1);
        end
        rx_word(32'h0003, 2);
        exp_addr_q.push_back(24'h1C); exp_addr_q.push_back(24'h10); exp_addr_q.push_back(24'h14);
        ctrl_data_tx_valid = 1'b1;
        ctrl_data_tx = 32'h11111111; exp_tx_q.push_back(32'h11111111);
        rx_word(32'h1C, 2);
        tick(1);
        ctrl_data_tx = 32'h22222222; exp_tx_q.push_back(32'h22222222);
        tx_done_pulse(4);
        tick(1);
        ctrl_data_tx = 32'h33333333; exp_tx_q.push_back(32'h33333333);
        tx_done_pulse(4);
        tick(2);
        checks++;
        if (exp_addr_q.size() != 0 || exp_tx_q.size() != 0) begin
            failures++;
            $display("FAIL wrap_queues addr_left=%0d tx_left=%0d exp 0 0", exp_addr_q.size(), exp_tx_q.size());
        end
        deselect();
        exp_tx_q.push_back(32'd4);
        rx_word(32'h0121, 2);
        checks++;
        if (tx_counter !== 8'd31 || tx_data_valid !== 1'b1) begin
            failures++;
            $display("FAIL regrd_load txc=%0d txv=%b exp 31 1", tx_counter, tx_data_valid);
        end
        tx_done_pulse(3);
        checks++;
        if (state_dbg !== S_CMD || rx_counter_upd !== 1'b1) begin
            failures++;
            $display("FAIL regrd_done st=%0d upd=%b exp 0 1", state_dbg, rx_counter_upd);
        end
        deselect();
    endtask

    task automatic test_underrun();
        rx_word(32'h0003, 2);
        exp_addr_q.push_back(24'h200); exp_addr_q.push_back(24'h204);
        ctrl_data_tx = 32'hCAFE0001; ctrl_data_tx_valid = 1'b1;
        exp_tx_q.push_back(32'hCAFE0001);
        rx_word(32'h200, 2);
        tick(1);
        checks++;
        if (underrun !== 1'b0) begin
            failures++;
            $display("FAIL underrun_early got=%b exp 0", underrun);
        end
        ctrl_data_tx_valid = 1'b0;
        exp_tx_q.push_back(32'h0);
        tx_done_pulse(3);
        tick(1);
        tick(5);
        checks++;
        if (underrun !== 1'b1) begin
            failures++;
            $display("FAIL underrun_sticky got=%b exp 1", underrun);
        end
        cs = 1'b1;
        #1;
        checks++;
        if (underrun !== 1'b0) begin
            failures++;
            $display("FAIL underrun_clear got=%b exp 0", underrun);
        end
        tick(2);
        cs = 1'b0;
        tick(1);
    endtask

    task automatic test_illegal();
        int bad = 0;
        rx_word(32'h005A, 2);
        checks++;
        if (illegal_cmd !== 1'b1 || state_dbg !== S_IGNORE || rx_counter_upd !== 1'b0) begin
            failures++;
            $display("FAIL illegal_flag ill=%b st=%0d upd=%b exp 1 %0d 0", illegal_cmd, state_dbg, rx_counter_upd, S_IGNORE);
        end
        for (int i = 0; i < 64; i++) begin
            rx_data = $urandom;
            rx_data_valid = (i % 8 == 0);
            tick(1);
            if (ctrl_addr_valid || ctrl_data_rx_valid || ctrl_data_tx_ready || tx_data_valid ||
                rx_counter_upd || tx_counter_upd) bad++;
        end
        rx_data_valid = 1'b0;
        checks++;
        if (bad != 0 || state_dbg !== S_IGNORE || illegal_cmd !== 1'b1) begin
            failures++;
            $display("FAIL illegal_quiet strobes=%0d st=%0d ill=%b exp 0 %0d 1", bad, state_dbg, illegal_cmd, S_IGNORE);
        end
        deselect();
        rx_word(32'h0003, 2);
        checks++;
        if (illegal_cmd !== 1'b0 || state_dbg !== S_ADDR || rx_counter !== 8'd23) begin
            failures++;
            $display("FAIL illegal_recover ill=%b st=%0d rxc=%0d exp 0 %0d 23", illegal_cmd, state_dbg, rx_counter, S_ADDR);
        end
        exp_addr_q.push_back(24'h40);
        ctrl_data_tx = 32'h0BADF00D; ctrl_data_tx_valid = 1'b1;
        exp_tx_q.push_back(32'h0BADF00D);
        rx_word(32'h40, 2);
        tick(2);
        deselect();
    endtask

    task automatic test_cs_abort();
        reg_write(8'h00, 32'd5);
        rx_word(32'h000B, 2);
        exp_addr_q.push_back(24'h300);
        rx_word(32'h300, 2);
        checks++;
        if (rx_counter !== 8'd4 || state_dbg !== S_DUMMY) begin
            failures++;
            $display("FAIL abort_dummy rxc=%0d st=%0d exp 4 %0d", rx_counter, state_dbg, S_DUMMY);
        end
        ctrl_data_tx = 32'h11112222; ctrl_data_tx_valid = 1'b1;
        exp_tx_q.push_back(32'h11112222);
        rx_word(32'h0, 3);
        tick(1);
        tick(3);
        tx_done = 1'b1;
        cs = 1'b1;
        #1;
        checks++;
        if (state_dbg !== S_CMD || rx_counter !== 8'(CMD_W - 1) || lanes !== 2'd0 || tx_data !== 32'h0 ||
            {ctrl_addr_valid, ctrl_data_rx_valid, ctrl_data_tx_ready, tx_data_valid, rx_counter_upd, tx_counter_upd} !== 6'h0) begin
            failures++;
            $display("FAIL abort_reset st=%0d rxc=%0d lanes=%0d txd=%h exp 0 %0d 0 0 with strobes 0", state_dbg, rx_counter, lanes, tx_data, CMD_W - 1);
        end
        tick(2);
        tx_done = 1'b0;
        cs = 1'b0;
        tick(2);
        exp_tx_q.push_back(32'd5);
        rx_word(32'h0021, 2);
        tx_done_pulse(2);
        exp_tx_q.push_back(32'd4);
        rx_word(32'h0121, 2);
        tx_done_pulse(2);
        tick(1);
        checks++;
        if (exp_tx_q.size() != 0 || exp_addr_q.size() != 0 || wrap_length !== 16'd4) begin
            failures++;
            $display("FAIL abort_retain tx_left=%0d addr_left=%0d wrap=%0d exp 0 0 4", exp_tx_q.size(), exp_addr_q.size(), wrap_length);
        end
        deselect();
    endtask

    task automatic test_dummy_skip();
        reg_write(8'h00, 32'd0);
        rx_word(32'h000B, 2);
        exp_addr_q.push_back(24'h400);
        ctrl_data_tx = 32'h44445555; ctrl_data_tx_valid = 1'b1;
        exp_tx_q.push_back(32'h44445555);
        rx_word(32'h400, 2);
        checks++;
        if (ctrl_data_tx_ready !== 1'b1 || state_dbg !== S_DATA_TX || rx_counter_upd !== 1'b0) begin
            failures++;
            $display("FAIL dummy_skip rdy=%b st=%0d upd=%b exp 1 %0d 0", ctrl_data_tx_ready, state_dbg, rx_counter_upd, S_DATA_TX);
        end
        tick(2);
        deselect();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_write_burst();
        test_quad_read();
        test_wrap();
        test_underrun();
        test_illegal();
        test_cs_abort();
        test_dummy_skip();
        tick(2);
        checks++;
        if (exp_addr_q.size() != 0 || exp_wr_q.size() != 0 || exp_tx_q.size() != 0) begin
            failures++;
            $display("FAIL final_queues addr=%0d wr=%0d tx=%0d exp 0 0 0", exp_addr_q.size(), exp_wr_q.size(), exp_tx_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
